// File: rtl/sum_ch_pkg.sv
// rtl/sum_ch_pkg.sv - shared constants and state type for the uplink sum scheduler
// Contents:
//   NUM_CH  - channels feeding the summer (fixed by the 4-input adder tree)
//   DW      - per-channel I/Q sample width
//   ADD_LAT - summer pipeline latency in clk cycles
//   FLW     - frame-length counter width
//   SUM_W   - summer output width (two adder stages, full precision)
//   state_t - scheduler FSM states
package sum_ch_pkg;

    localparam int NUM_CH  = 4;
    localparam int DW      = 16;
    localparam int ADD_LAT = 2;
    localparam int FLW     = 16;
    localparam int SUM_W   = DW + 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sum_ch_if.sv
// rtl/sum_ch_if.sv - per-channel I/Q sample stream bundle (valid/ready handshake)
// Signals:
//   ch_valid  - per-channel sample valid (source -> scheduler)
//   ch_ready  - per-channel pop; a sample is consumed when valid & ready
//   ch_data_i - I samples, channel n at [n*DW +: DW]
//   ch_data_q - Q samples, channel n at [n*DW +: DW]
// Modports: master = sample source, slave = scheduler.
interface sum_ch_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 16
);

    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_ready;
    logic [NUM_CH*DW-1:0] ch_data_i;
    logic [NUM_CH*DW-1:0] ch_data_q;

    modport master (
        output ch_valid,
        output ch_data_i,
        output ch_data_q,
        input  ch_ready
    );

    modport slave (
        input  ch_valid,
        input  ch_data_i,
        input  ch_data_q,
        output ch_ready
    );

endinterface

// File: rtl/sum_ch_summer.sv
// rtl/sum_ch_summer.sv - 4-channel I/Q adder tree, two registered stages, full precision
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   in_i / in_q  - four signed samples each, channel n at [n*DW +: DW]
//   sum_i/sum_q  - signed DW+2 bit sum, valid ADD_LAT (2) cycles after the inputs
module sum_ch_summer
    import sum_ch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*DW-1:0]    in_i,
    input  logic [NUM_CH*DW-1:0]    in_q,
    output logic signed [SUM_W-1:0] sum_i,
    output logic signed [SUM_W-1:0] sum_q
);

    logic signed [DW:0] p01_i, p23_i, p01_q, p23_q;

    // Sign-extend one sample to the first-stage width.
    function automatic logic signed [DW:0] sx1(input logic [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            p01_i <= '0;
            p23_i <= '0;
            p01_q <= '0;
            p23_q <= '0;
            sum_i <= '0;
            sum_q <= '0;
        end else begin
            p01_i <= sx1(in_i[0*DW +: DW]) + sx1(in_i[1*DW +: DW]);
            p23_i <= sx1(in_i[2*DW +: DW]) + sx1(in_i[3*DW +: DW]);
            p01_q <= sx1(in_q[0*DW +: DW]) + sx1(in_q[1*DW +: DW]);
            p23_q <= sx1(in_q[2*DW +: DW]) + sx1(in_q[3*DW +: DW]);
            sum_i <= {p01_i[DW], p01_i} + {p23_i[DW], p23_i};
            sum_q <= {p01_q[DW], p01_q} + {p23_q[DW], p23_q};
        end
    end

endmodule

// File: rtl/sum_ch_vld_dly.sv
// rtl/sum_ch_vld_dly.sv - fixed-depth shift register that carries fire markers alongside the summer pipeline
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears every stage
//   din  - marker bits entering the line
//   dout - marker bits after DEPTH cycles
module sum_ch_vld_dly #(
    parameter int DEPTH = 3,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sum_ch_sched.sv
// rtl/sum_ch_sched.sv - four-channel uplink sum scheduler: aligns, masks and registers samples for the summer
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   cfg_ch_en         - requested channel enable mask (taken at frame boundaries)
//   cfg_frame_len     - samples per frame, 0 behaves as 1 (taken at frame boundaries)
//   cfg_stall_max     - stall timeout in cycles, 0 disables the timeout
//   ch                - per-channel valid/ready/data streams (slave side)
//   sum_in_i/sum_in_q - registered masked samples for the summer
//   sum_vld           - valid, aligned with the summer output
//   frame_start/end   - frame markers aligned with sum_vld
//   underrun          - sticky, set by any timeout-forced fire
//   underrun_cnt      - saturating count of timeout-forced fires
//   busy              - scheduler is in RUN
module sum_ch_sched #(
    parameter int NUM_CH  = sum_ch_pkg::NUM_CH,
    parameter int DW      = sum_ch_pkg::DW,
    parameter int ADD_LAT = sum_ch_pkg::ADD_LAT,
    parameter int FLW     = sum_ch_pkg::FLW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    cfg_ch_en,
    input  logic [FLW-1:0]       cfg_frame_len,
    input  logic [7:0]           cfg_stall_max,
    sum_ch_if.slave              ch,
    output logic [NUM_CH*DW-1:0] sum_in_i,
    output logic [NUM_CH*DW-1:0] sum_in_q,
    output logic                 sum_vld,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 underrun,
    output logic [15:0]          underrun_cnt,
    output logic                 busy
);

    import sum_ch_pkg::*;

    state_t              state;
    logic [NUM_CH-1:0]   act_en;
    logic [FLW-1:0]      flen;
    logic [FLW-1:0]      samp_cnt;
    logic [7:0]          stall_cnt;

    logic                fire_all;
    logic                any_vld;
    logic                timeout;
    logic                fire;
    logic                is_last;
    logic [FLW-1:0]      last_idx;
    logic [NUM_CH-1:0]   pop;
    logic [2:0]          mark_in;
    logic [2:0]          mark_out;

    always_comb begin
        // Disabled channels never hold up a fire.
        fire_all = &(ch.ch_valid | ~act_en);
        any_vld  = |(ch.ch_valid & act_en);
        timeout  = (cfg_stall_max != 8'd0) && (stall_cnt == cfg_stall_max);
        fire     = (state == RUN) && (fire_all || timeout);
        last_idx = (flen <= FLW'(1)) ? '0 : flen - FLW'(1);
        is_last  = (samp_cnt == last_idx);
        pop      = fire ? (act_en & ch.ch_valid) : '0;
        mark_in  = {fire, fire && (samp_cnt == '0), fire && is_last};
    end

    assign ch.ch_ready = pop;
    assign busy        = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            act_en       <= '0;
            flen         <= '0;
            samp_cnt     <= '0;
            stall_cnt    <= '0;
            sum_in_i     <= '0;
            sum_in_q     <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    act_en    <= cfg_ch_en;
                    flen      <= cfg_frame_len;
                    samp_cnt  <= '0;
                    stall_cnt <= '0;
                    if (cfg_ch_en != '0) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fire) begin
                        stall_cnt <= '0;
                        // Popped channels carry data; missing or disabled ones are zeroed.
                        for (int n = 0; n < NUM_CH; n++) begin
                            sum_in_i[n*DW +: DW] <= pop[n] ? ch.ch_data_i[n*DW +: DW] : '0;
                            sum_in_q[n*DW +: DW] <= pop[n] ? ch.ch_data_q[n*DW +: DW] : '0;
                        end
                        // A timeout that coincides with everyone arriving is a normal fire.
                        if (!fire_all) begin
                            underrun <= 1'b1;
                            if (underrun_cnt != 16'hFFFF) begin
                                underrun_cnt <= underrun_cnt + 16'd1;
                            end
                        end
                        if (is_last) begin
                            samp_cnt <= '0;
                            act_en   <= cfg_ch_en;
                            flen     <= cfg_frame_len;
                            if (cfg_ch_en == '0) begin
                                state <= IDLE;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + FLW'(1);
                        end
                    end else if (any_vld && (stall_cnt != 8'hFF)) begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One cycle for the sum_in register plus the summer's own latency.
    sum_ch_vld_dly #(
        .DEPTH (ADD_LAT + 1),
        .W     (3)
    ) u_vld_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (mark_in),
        .dout (mark_out)
    );

    assign sum_vld     = mark_out[2];
    assign frame_start = mark_out[1];
    assign frame_end   = mark_out[0];

endmodule

// File: tb/tb_sum_ch_sched.sv
// tb/tb_sum_ch_sched.sv - directed self-checking bench for sum_ch_sched with the summer alongside
module tb_sum_ch_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  cfg_ch_en;
    logic [15:0] cfg_frame_len;
    logic [7:0]  cfg_stall_max;
    logic [63:0] sum_in_i, sum_in_q;
    logic        sum_vld, frame_start, frame_end, underrun, busy;
    logic [15:0] underrun_cnt;
    logic signed [17:0] sum_i, sum_q;

    int checks   = 0;
    int failures = 0;

    sum_ch_if #(.NUM_CH(4), .DW(16)) ch_if ();

    sum_ch_sched u_dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_ch_en     (cfg_ch_en),
        .cfg_frame_len (cfg_frame_len),
        .cfg_stall_max (cfg_stall_max),
        .ch            (ch_if),
        .sum_in_i      (sum_in_i),
        .sum_in_q      (sum_in_q),
        .sum_vld       (sum_vld),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .underrun      (underrun),
        .underrun_cnt  (underrun_cnt),
        .busy          (busy)
    );

    sum_ch_summer u_sum (
        .clk   (clk),
        .rst   (rst),
        .in_i  (sum_in_i),
        .in_q  (sum_in_q),
        .sum_i (sum_i),
        .sum_q (sum_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] en, input logic [15:0] fl,
                            input logic [7:0] smax, input logic [3:0] vld);
        rst = 1'b1;
        step();
        step();
        step();
        cfg_ch_en        = en;
        cfg_frame_len    = fl;
        cfg_stall_max    = smax;
        ch_if.ch_valid   = vld;
        rst              = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        cfg_ch_en        = 4'hF;
        cfg_frame_len    = 16'd4;
        cfg_stall_max    = 8'd0;
        ch_if.ch_valid   = 4'hF;
        ch_if.ch_data_i  = {16'd400, 16'd300, 16'd200, 16'd100};
        ch_if.ch_data_q  = {16'd4, 16'd3, 16'd2, 16'd1};

        // Reset held three cycles with all channels valid.
        step(); step(); step();
        #1;
        chk("rst_ready",  ch_if.ch_ready, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_vld",    sum_vld, 0);
        chk("rst_fs_fe",  {frame_start, frame_end}, 0);
        chk("rst_sum_in", sum_in_i, 0);
        chk("rst_undr",   {underrun, underrun_cnt}, 0);

        // All four channels, frame length 4.
        do_reset(4'hF, 16'd4, 8'd0, 4'hF);
        step();                                   // P1: RUN, first fire
        chk("full_busy",  busy, 1);
        chk("full_ready", ch_if.ch_ready, 4'hF);
        step();                                   // P2
        chk("full_sum_in", sum_in_i, {16'd400, 16'd300, 16'd200, 16'd100});
        chk("full_vld_p2", sum_vld, 0);
        step();                                   // P3
        chk("full_vld_p3", sum_vld, 0);
        step();                                   // P4: first output
        chk("full_vld",   sum_vld, 1);
        chk("full_sum_i", 64'(sum_i), 1000);
        chk("full_sum_q", 64'(sum_q), 10);
        chk("full_fs0",   {frame_start, frame_end}, 2'b10);
        for (int k = 1; k < 8; k++) begin
            step();
            chk("full_vld_k", sum_vld, 1);
            chk("full_fs_fe", {frame_start, frame_end}, {(k % 4) == 0, (k % 4) == 3});
        end

        // Mask 0101 with every channel valid.
        do_reset(4'h5, 16'd4, 8'd0, 4'hF);
        step();
        chk("mask_ready", ch_if.ch_ready, 4'h5);
        step();
        chk("mask_sum_in_i", sum_in_i, {16'd0, 16'd300, 16'd0, 16'd100});
        chk("mask_sum_in_q", sum_in_q, {16'd0, 16'd3, 16'd0, 16'd1});
        step();
        step();
        chk("mask_vld",   sum_vld, 1);
        chk("mask_sum_i", 64'(sum_i), 400);

        // ch2 missing, timeout after 3 stalled cycles.
        do_reset(4'hF, 16'd4, 8'd3, 4'b1011);
        step(); chk("stall_rdy1", ch_if.ch_ready, 0);
        step(); chk("stall_rdy2", ch_if.ch_ready, 0);
        step(); chk("stall_rdy3", ch_if.ch_ready, 0);
        step();                                   // P4: stall_cnt reaches 3
        chk("stall_fire_rdy", ch_if.ch_ready, 4'b1011);
        chk("stall_undr_pre", underrun, 0);
        step();                                   // P5
        chk("stall_undr",     underrun, 1);
        chk("stall_undr_cnt", underrun_cnt, 1);
        chk("stall_sum_in",   sum_in_i, {16'd400, 16'd0, 16'd200, 16'd100});
        chk("stall_rdy_after", ch_if.ch_ready, 0);
        step();                                   // P6
        chk("stall_hold",     sum_in_i, {16'd400, 16'd0, 16'd200, 16'd100});
        step();                                   // P7: output of the forced fire
        chk("stall_vld",      sum_vld, 1);
        chk("stall_sum_i",    64'(sum_i), 700);
        chk("stall_fs",       frame_start, 1);
        chk("stall_cnt_hold", underrun_cnt, 1);

        // Last missing channel arrives in the timeout cycle: normal fire.
        do_reset(4'hF, 16'd4, 8'd2, 4'b1011);
        step(); step(); step();                   // P3: stall_cnt == 2
        ch_if.ch_valid = 4'hF;
        #1;
        chk("coinc_ready", ch_if.ch_ready, 4'hF);
        step();
        chk("coinc_undr",   {underrun, underrun_cnt}, 0);
        chk("coinc_sum_in", sum_in_i, {16'd400, 16'd300, 16'd200, 16'd100});

        // Frame length 0 behaves as 1: every sample starts and ends a frame.
        do_reset(4'hF, 16'd0, 8'd0, 4'hF);
        step(); step(); step(); step();
        chk("flen0_a", {sum_vld, frame_start, frame_end}, 3'b111);
        step();
        chk("flen0_b", {sum_vld, frame_start, frame_end}, 3'b111);

        // Mask change mid-frame waits for the boundary; then 0 returns to IDLE.
        do_reset(4'hF, 16'd4, 8'd0, 4'hF);
        step();                                   // P1: sample 0
        step();                                   // P2: sample 1
        cfg_ch_en = 4'h3;
        #1;
        chk("mid_rdy2", ch_if.ch_ready, 4'hF);
        step(); chk("mid_rdy3", ch_if.ch_ready, 4'hF);
        step(); chk("mid_rdy4", ch_if.ch_ready, 4'hF);
        step();                                   // P5: new mask in effect
        chk("mid_rdy5", ch_if.ch_ready, 4'h3);
        cfg_ch_en = 4'h0;
        step(); step();
        step();                                   // P8
        chk("mid_busy8",  busy, 1);
        chk("mid_vld8",   {sum_vld, frame_start}, 2'b11);
        chk("mid_sum8",   64'(sum_i), 300);
        step();                                   // P9
        chk("mid_busy9",  busy, 0);
        chk("mid_rdy9",   ch_if.ch_ready, 0);
        step(); step();                           // P11
        chk("mid_fe11",   {sum_vld, frame_end}, 2'b11);
        step();
        chk("mid_vld12",  sum_vld, 0);

        // One-cycle reset mid-frame with fires in flight.
        do_reset(4'hF, 16'd4, 8'd0, 4'hF);
        step(); step(); step(); step();           // P4
        chk("rmid_vld_pre", sum_vld, 1);
        rst = 1'b1;
        step();                                   // P5
        chk("rmid_vld0", sum_vld, 0);
        chk("rmid_busy", busy, 0);
        rst = 1'b0;
        step(); chk("rmid_vld6", sum_vld, 0);
        step(); chk("rmid_vld7", sum_vld, 0);
        step(); chk("rmid_vld8", sum_vld, 0);
        step();                                   // P9
        chk("rmid_restart", {sum_vld, frame_start, frame_end}, 3'b110);
        chk("rmid_sum",     64'(sum_i), 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
